// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder: single-outstanding data-memory responder, fixed LATENCY, byte/half/word lanes.
// Option: DMEM_RESP_MISALIGN_TRAP_EN makes misaligned half/word accesses errors. Rev 1.0
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_sign_ext,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_below;
  logic [29:0]         w_word_off;
  logic                w_out_range;
  logic [c_IDX_W-1:0]  w_index;
  logic                w_size_rsvd;
  logic                w_misalign;
  logic                w_err;
  logic [31:0]         w_rword;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [3:0]          w_be;
  logic [31:0]         w_wword;
  logic [31:0]         w_load;

  assign w_accept    = (r_state == S_IDLE) && i_req_valid;
  assign w_below     = i_req_addr < ADDR_BASE;
  // Word offset from the base; the low two address bits only select lanes.
  assign w_word_off  = i_req_addr[31:2] - ADDR_BASE[31:2];
  assign w_out_range = w_below || (w_word_off[29:c_IDX_W] != '0);
  assign w_index     = w_word_off[c_IDX_W-1:0];
  assign w_size_rsvd = (i_req_size == 2'd3);

`ifdef DMEM_RESP_MISALIGN_TRAP_EN
  assign w_misalign  = ((i_req_size == 2'd1) && i_req_addr[0]) ||
                       ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00));
`else
  assign w_misalign  = 1'b0;
`endif

  assign w_err       = w_out_range || w_size_rsvd || w_misalign;
  assign w_rword     = r_mem[w_index];
  assign w_byte      = w_rword[{i_req_addr[1:0], 3'b000} +: 8];
  assign w_half      = i_req_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_be    = 4'b0000;
    w_wword = 32'h0;
    w_load  = 32'h0;
    case (i_req_size)
      2'd0: begin
        w_be    = 4'b0001 << i_req_addr[1:0];
        w_wword = {4{i_req_wdata[7:0]}};
        w_load  = i_req_sign_ext ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      2'd1: begin
        w_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{i_req_wdata[15:0]}};
        w_load  = i_req_sign_ext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      2'd2: begin
        w_be    = 4'b1111;
        w_wword = i_req_wdata;
        w_load  = w_rword;
      end
      default: begin
        w_be    = 4'b0000;
      end
    endcase
  end

  // Array has no reset; a store accepted before reset stays committed.
  always_ff @(posedge i_clock) begin
    if (i_reset && w_accept && i_req_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_index][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= c_CNT_INIT;
            r_rdata <= (i_req_write || w_err) ? 32'h0 : w_load;
            r_err   <= w_err;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder: directed + random bench against a lane-arithmetic memory model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_sign_ext = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_write    (req_write),
    .i_req_size     (req_size),
    .i_req_sign_ext (req_sign_ext),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL timeout %s: got no handshake expected one within 40 cycles at %0t", nm, $time);
  endtask

  // Reference model: flat word array plus "cycles since accept" bookkeeping.
  logic [31:0] mm [DEPTH];
  bit          m_pend = 1'b0;
  int          m_age  = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_err = 1'b0;
  bit          chk_en = 1'b0;

  function automatic void m_access(input logic [31:0] a, input logic [31:0] wd, input bit w,
                                   input logic [1:0] sz, input bit se,
                                   output logic [31:0] rd, output bit er);
    longint      off;
    int          idx;
    int          sh;
    logic [31:0] mask;
    logic [31:0] v;
    rd  = 32'h0;
    er  = 1'b0;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off / 4 >= DEPTH || sz == 2'd3) er = 1'b1;
`ifdef DMEM_RESP_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) er = 1'b1;
`endif
    if (er) return;
    idx = int'(off / 4);
    case (sz)
      2'd0:    begin mask = 32'h0000_00FF; sh = int'(a[1:0]) * 8; end
      2'd1:    begin mask = 32'h0000_FFFF; sh = int'(a[1]) * 16; end
      default: begin mask = 32'hFFFF_FFFF; sh = 0; end
    endcase
    if (w) begin
      mm[idx] = (mm[idx] & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      v = (mm[idx] >> sh) & mask;
      if (se && sz != 2'd2 && (v & ((mask >> 1) + 32'd1)) != 32'h0) v = v | ~mask;
      rd = v;
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 1'b0;
    end else if (!m_pend) begin
      if (req_valid) begin
        m_access(req_addr, req_wdata, req_write, req_size, req_sign_ext, m_rdata, m_err);
        m_pend = 1'b1;
        m_age  = 0;
      end
    end else if (m_age >= LAT && resp_ready) begin
      m_pend = 1'b0;
    end else if (m_age < 1000) begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!m_pend));
      chk("resp_valid", 32'(resp_valid), 32'(m_pend && m_age >= LAT));
      if (m_pend && m_age >= LAT) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
    end
  end

  logic [31:0] rd;
  logic        er;
  int          lat;

  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input bit w,
                      input logic [1:0] sz, input bit se, input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin n++; @(negedge clk); end
    if (!req_ready) timeout("req_ready");
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_write = w;
    req_size = sz; req_sign_ext = se;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_write = 1'($urandom); req_size = 2'($urandom); req_sign_ext = 1'($urandom);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 40) begin n++; @(negedge clk); end
    if (!resp_valid) timeout("resp_valid");
    lat = n;
    rd  = resp_rdata;
    er  = resp_err;
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h1);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", 32'(resp_err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) xact(BASE + 32'(4 * i), 32'h0, 1'b1, 2'd2, 1'b0, 0);
    xact(BASE + 32'(4 * 1023), 32'h0, 1'b1, 2'd2, 1'b0, 0);

    xact(32'h0100_0000, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 0);
    chk("store latency", 32'(lat), 32'd2);
    chk("store err", 32'(er), 32'h0);
    chk("store rdata", rd, 32'h0);
    xact(32'h0100_0000, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("load word", rd, 32'hDEAD_BEEF);

    xact(32'h0100_0005, 32'h0000_0080, 1'b1, 2'd0, 1'b0, 0);
    xact(32'h0100_0005, 32'h0, 1'b0, 2'd0, 1'b1, 0);
    chk("load byte sext", rd, 32'hFFFF_FF80);
    xact(32'h0100_0005, 32'h0, 1'b0, 2'd0, 1'b0, 0);
    chk("load byte zext", rd, 32'h0000_0080);
    xact(32'h0100_0004, 32'h0, 1'b0, 2'd2, 1'b0, 5);
    chk("load word lanes", rd, 32'h0000_8000);

    xact(32'h00FF_FFFC, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("below base err", 32'(er), 32'h1);
    chk("below base rdata", rd, 32'h0);
    xact(32'h0100_1000, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("above top err", 32'(er), 32'h1);
    chk("above top rdata", rd, 32'h0);
    xact(32'h0100_1000, 32'h5555_5555, 1'b1, 2'd2, 1'b0, 0);
    xact(32'h00FF_FFFC, 32'hAAAA_AAAA, 1'b1, 2'd2, 1'b0, 0);
    xact(32'h0100_0000, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("readback word0", rd, 32'hDEAD_BEEF);
    xact(BASE + 32'(4 * 1023), 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("readback word1023", rd, 32'h0);

    xact(32'h0100_0003, 32'h0000_1234, 1'b1, 2'd1, 1'b0, 0);
`ifdef DMEM_RESP_MISALIGN_TRAP_EN
    chk("misaligned half err", 32'(er), 32'h1);
    xact(32'h0100_0000, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("misaligned half no write", rd, 32'hDEAD_BEEF);
`else
    chk("misaligned half err", 32'(er), 32'h0);
    xact(32'h0100_0000, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("misaligned half lanes", rd, 32'h1234_BEEF);
`endif

    xact(32'h0100_0008, 32'hFFFF_FFFF, 1'b1, 2'd3, 1'b0, 0);
    chk("reserved size err", 32'(er), 32'h1);
    xact(32'h0100_0008, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("reserved size no write", rd, 32'h0);

    // Reset lands on the first edge of the latency wait after a store.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0100_000C; req_wdata = 32'hCAFE_F00D;
    req_write = 1'b1; req_size = 2'd2; req_sign_ext = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("wait rst req_ready", 32'(req_ready), 32'h1);
    chk("wait rst resp_valid", 32'(resp_valid), 32'h0);
    chk("wait rst resp_rdata", resp_rdata, 32'h0);
    chk("wait rst resp_err", 32'(resp_err), 32'h0);
    repeat (4) @(negedge clk);
    xact(32'h0100_000C, 32'h0, 1'b0, 2'd2, 1'b0, 0);
    chk("store survives reset", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) begin
        a = ($urandom_range(1) == 0) ? BASE - 32'($urandom_range(64, 1))
                                     : BASE + 32'(4 * DEPTH) + 32'($urandom_range(255));
      end else begin
        a = BASE + 32'($urandom_range(255));
      end
      sz = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      xact(a, $urandom, 1'($urandom), sz, 1'($urandom), $urandom_range(2));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the pipeline's data-memory interface: accepts one load/store request at a time over a valid/ready handshake and returns a response after a fixed, parameterised latency. It sits between the memory stage and a word-organised data array. It lets the core be exercised against multi-cycle memory timing instead of a single-cycle array. It handles byte/half/word lanes, little-endian packing, load sign extension, and address range and alignment checking.

## Interface
- `ADDR_BASE`, default 32'h01000000: byte address of word 0 of the array.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two.
- `LATENCY`, default 2: number of cycles from the request-accept edge to the first `resp_valid`; legal range 1..15.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_sign_ext`  in  1  loads only: sign-extend byte/half.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester takes the response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  out-of-range, reserved size, or misaligned (see Configuration).

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: counting latency.
  - RESP: `resp_valid`=1.
- IDLE→WAIT when `req_valid && req_ready` at an edge. On that same edge:
  - Capture the response data and error.
  - Perform the store if there is no error.
  - Load the counter with `LATENCY-1`.
- WAIT: decrement the counter each edge. At 0, move to RESP. With LATENCY=1, go IDLE→RESP directly.
- RESP: hold `resp_rdata`/`resp_err` stable until `resp_valid && resp_ready`, then go to IDLE. There is no bypass to a new request on the same edge.
- Word index = `(req_addr - ADDR_BASE) >> 2`.
- Out of range (address below base, or index ≥ DEPTH_WORDS): `resp_err`=1, no store, `resp_rdata`=0.
- `req_size`=3: error, same handling as out of range.
- Store lanes, little-endian:
  - Byte: write `wdata[7:0]` to lane `addr[1:0]`.
  - Half: write `wdata[15:0]` to lanes `addr[1]*2`+{0,1}.
  - Word: write all four lanes.
  - Other lanes are unchanged.
- Load: extract the same lanes and right-align them. Byte/half are sign-extended if `req_sign_ext`=1, otherwise zero-extended.
- Only one request is outstanding, so a load after a store always sees the stored data.
- Array contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset (`reset`=0 at an edge): next state is IDLE.
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0.
- Reset mid-operation: the pending response is dropped. A store accepted before reset stays committed.
- `req_ready` and `resp_valid` are decoded from registered state only; they have no combinational path from `req_valid`/`resp_ready`.
- Request accepted at edge T → `resp_valid` rises after edge T+LATENCY.
- Minimum request-to-request spacing is LATENCY+1 cycles (the consume edge plus a return to IDLE).
- Backpressure: `resp_ready`=0 holds RESP indefinitely, with outputs frozen.
- `req_*` are sampled only at the accept edge and ignored at all other times.

## Configuration
- `DMEM_RESP_MISALIGN_TRAP_EN` defined: misalignment is an error.
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Such requests set `resp_err`=1, suppress the store, and return `resp_rdata`=0.
- Not defined: low address bits are ignored for the access.
  - Half uses `addr[1]` only; word ignores `addr[1:0]`.
  - No error is raised; the access proceeds as if aligned.

## Test plan
- Reset then store word 32'hDEADBEEF @01000000 with LATENCY=2:
  - `resp_valid` rises 2 edges after accept, with `resp_err`=0 and `rdata`=0.
  - A following word load returns DEADBEEF.
- Store byte 8'h80 @01000005, then load byte @01000005:
  - With sign_ext=1 → FFFFFF80; with sign_ext=0 → 00000080.
  - Word load @01000004 → 00008000 (other lanes unchanged from a prior zero fill).
- Hold `resp_ready`=0 for 5 cycles in RESP:
  - `resp_valid`/`rdata` stay constant and `req_ready`=0.
  - After `resp_ready`=1, `req_ready`=1 on the next cycle.
- Load @00FFFFFC and @01001000 (DEPTH 1024):
  - Both give `resp_err`=1, `rdata`=0.
  - Array contents are unchanged (verified by readback).
- Half store @01000003 with the macro defined:
  - `resp_err`=1 and no write.
- Same half store with the macro undefined:
  - `resp_err`=0, and the data lands in lanes 2–3.
- Reset asserted during WAIT after a store:
  - Outputs go to reset values and no response is produced.
  - A subsequent load still returns the stored data.
